// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: load/store unit between the multicycle MIPS core and an
// Avalon memory-mapped master port.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_i, we_i, size_i,       core request: start, store/load, size
//   sign_ext_i, addr_i,        (0 byte, 1 half, 2/3 word), load extension,
//   wdata_i                    byte address, right-justified store data
//   busy_o, done_o, rdata_o,   core status: busy, one-cycle completion,
//   misalign_o, timeout_o      extended load data, error flags
//   address, write, read,      Avalon master: word-aligned address,
//   waitrequest, writedata,    strobes, stall, lane-formatted store data,
//   byteenable, readdata       byte lanes, read data
//
// One core request becomes exactly one Avalon transfer. Bus-side fields
// are registered when the request is accepted and held for the whole
// transfer, so they stay stable across waitrequest stalls.
`timescale 1ns/1ps

module mips_bus_lsu #(
  parameter int BIG_ENDIAN_CORE = 1,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_sign;
  logic [1:0]           r_off;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0]          r_address;
  logic [31:0]          r_writedata;
  logic [3:0]           r_byteenable;
  logic [31:0]          r_rdata;
  logic                 r_misalign;
  logic                 r_timeout;

  // ---------------------------------------------------------------
  // Request decode (IDLE side)
  // ---------------------------------------------------------------
  logic [1:0]  w_off;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_wb0;
  logic [7:0]  w_wb1;

  assign w_off     = addr_i[1:0];
  assign w_is_byte = (size_i == 2'd0);
  assign w_is_half = (size_i == 2'd1);
  // Size 3 is treated as a word everywhere.
  assign w_misaligned = (w_is_half && w_off[0]) ||
                        (!w_is_byte && !w_is_half && (w_off != 2'd0));

  assign w_wb0 = wdata_i[7:0];
  assign w_wb1 = wdata_i[15:8];

  always_comb begin
    w_be = 4'b1111;
    if (w_is_byte) begin
      w_be = 4'b0001 << w_off;
    end else if (w_is_half) begin
      w_be = w_off[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Byte and half data are replicated on every lane so the slave picks
  // the right one via byteenable; no shifting by offset is needed.
  always_comb begin
    w_wdata = wdata_i;
    if (BIG_ENDIAN_CORE != 0) begin
      if (w_is_byte) begin
        w_wdata = {4{w_wb0}};
      end else if (w_is_half) begin
        w_wdata = {2{w_wb0, w_wb1}};
      end else begin
        w_wdata = {wdata_i[7:0], wdata_i[15:8], wdata_i[23:16], wdata_i[31:24]};
      end
    end else begin
      if (w_is_byte) begin
        w_wdata = {4{w_wb0}};
      end else if (w_is_half) begin
        w_wdata = {2{wdata_i[15:0]}};
      end
    end
  end

  // ---------------------------------------------------------------
  // Load data formatting (BUS side, uses latched offset/size/sign)
  // ---------------------------------------------------------------
  logic [7:0]  w_lane [4];
  logic [7:0]  w_hbyte;
  logic [7:0]  w_lbyte;
  logic [15:0] w_half;
  logic [31:0] w_word;
  logic [31:0] w_load;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = readdata[8*gi +: 8];
    end
  endgenerate

  // Half accesses are aligned, so the pair is lanes {off[1],0} and {off[1],1}.
  assign w_lbyte = w_lane[{r_off[1], 1'b0}];
  assign w_hbyte = w_lane[{r_off[1], 1'b1}];
  assign w_half  = (BIG_ENDIAN_CORE != 0) ? {w_lbyte, w_hbyte} : {w_hbyte, w_lbyte};
  assign w_word  = (BIG_ENDIAN_CORE != 0) ?
                   {w_lane[0], w_lane[1], w_lane[2], w_lane[3]} : readdata;

  always_comb begin
    w_load = w_word;
    if (r_size == 2'd0) begin
      w_load = {{24{r_sign & w_lane[r_off][7]}}, w_lane[r_off]};
    end else if (r_size == 2'd1) begin
      w_load = {{16{r_sign & w_half[15]}}, w_half};
    end
  end

  logic w_timeout_hit;
  assign w_timeout_hit = TO_EN && (r_cnt == TO_LAST);

  // ---------------------------------------------------------------
  // FSM and registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_sign       <= 1'b0;
      r_off        <= 2'd0;
      r_cnt        <= '0;
      r_address    <= 32'd0;
      r_writedata  <= 32'd0;
      r_byteenable <= 4'd0;
      r_rdata      <= 32'd0;
      r_misalign   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we       <= we_i;
            r_size     <= size_i;
            r_sign     <= sign_ext_i;
            r_off      <= w_off;
            r_misalign <= w_misaligned;
            r_timeout  <= 1'b0;
            if (w_misaligned) begin
              // No bus access; rdata_o keeps its previous value.
              r_state <= S_DONE;
            end else begin
              r_state      <= S_BUS;
              r_cnt        <= '0;
              r_address    <= {addr_i[31:2], 2'b00};
              r_byteenable <= w_be;
              r_writedata  <= w_wdata;
            end
          end
        end
        S_BUS: begin
          if (waitrequest) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout_hit) begin
              r_state   <= S_DONE;
              r_timeout <= 1'b1;
              r_rdata   <= 32'd0;
            end
          end else begin
            if (!r_we) begin
              r_rdata <= w_load;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state so they drop in the same
  // cycle the FSM leaves BUS (including on reset).
  assign read       = (r_state == S_BUS) && !r_we;
  assign write      = (r_state == S_BUS) && r_we;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign address    = r_address;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign rdata_o    = r_rdata;
  assign misalign_o = r_misalign;
  assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_mips_bus_lsu.sv
`timescale 1ns/1ps

module tb_mips_bus_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sign_ext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        timeout_o;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata;
  int          ncyc;

  always #5 clk = ~clk;

  mips_bus_lsu #(
    .BIG_ENDIAN_CORE(1),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .sign_ext_i (sign_ext_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o),
    .timeout_o  (timeout_o),
    .address    (address),
    .write      (write),
    .read       (read),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (byte-level view) ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] s);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] s);
    logic [3:0] be = 4'd0;
    for (int j = 0; j < nbytes(s); j++) be[(a % 4) + j] = 1'b1;
    return be;
  endfunction

  // Big-endian core: the lowest address holds the most significant byte.
  function automatic logic [7:0] store_byte(input logic [31:0] w, input logic [1:0] s, input int j);
    return w[8*(nbytes(s)-1-j) +: 8];
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] s, input logic sx);
    logic [31:0] v = 32'd0;
    int n = nbytes(s);
    int off = a % 4;
    for (int j = 0; j < n; j++) v = (v << 8) | 32'(rd[8*(off+j) +: 8]);
    if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
    return v;
  endfunction

  // One full request; nwait = stall cycles before waitrequest drops.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int nwait, output int bus_cycles);
    bit timed;
    logic [3:0] ebe;
    @(negedge clk);
    chk("busy_before_req", {31'd0, busy_o}, 32'd0);
    req_i = 1'b1; we_i = we; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    waitrequest = 1'b1; readdata = $urandom;
    @(negedge clk);
    req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; size_i = 2'($urandom);
    bus_cycles = 0;
    if (is_misaligned(a, sz)) begin
      chk("mis_read", {31'd0, read}, 32'd0);
      chk("mis_write", {31'd0, write}, 32'd0);
      chk("mis_done", {31'd0, done_o}, 32'd1);
      chk("mis_flag", {31'd0, misalign_o}, 32'd1);
      chk("mis_timeout", {31'd0, timeout_o}, 32'd0);
      chk("mis_rdata", rdata_o, exp_rdata);
    end else begin
      timed = (nwait >= TO);
      ebe = model_be(a, sz);
      for (int k = 0; k < TO; k++) begin
        bus_cycles++;
        chk("bus_read", {31'd0, read}, {31'd0, !we});
        chk("bus_write", {31'd0, write}, {31'd0, we});
        chk("bus_address", address, {a[31:2], 2'b00});
        chk("bus_byteenable", {28'd0, byteenable}, {28'd0, ebe});
        chk("bus_done_low", {31'd0, done_o}, 32'd0);
        if (we) begin
          for (int j = 0; j < nbytes(sz); j++)
            chk("bus_wdata_lane", {24'd0, writedata[8*((a % 4)+j) +: 8]},
                {24'd0, store_byte(wd, sz, j)});
        end
        if (k < nwait) begin
          waitrequest = 1'b1; readdata = $urandom;
        end else begin
          waitrequest = 1'b0; readdata = rd;
        end
        @(negedge clk);
        if (k >= nwait) break;
      end
      waitrequest = 1'b1; readdata = $urandom;
      if (timed) exp_rdata = 32'd0;
      else if (!we) exp_rdata = load_value(rd, a, sz, sx);
      chk("done_pulse", {31'd0, done_o}, 32'd1);
      chk("done_read", {31'd0, read}, 32'd0);
      chk("done_write", {31'd0, write}, 32'd0);
      chk("done_misalign", {31'd0, misalign_o}, 32'd0);
      chk("done_timeout", {31'd0, timeout_o}, {31'd0, timed});
      chk("done_rdata", rdata_o, exp_rdata);
    end
    @(negedge clk);
    chk("after_done_low", {31'd0, done_o}, 32'd0);
    chk("after_busy_low", {31'd0, busy_o}, 32'd0);
    chk("after_rdata_held", rdata_o, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sign_ext_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0; waitrequest = 1'b1; readdata = 32'd0;
    exp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_flags", {30'd0, misalign_o, timeout_o}, 32'd0);
    reset = 1'b0;

    // Word load, zero wait states.
    run_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'd0, 32'h4433_2211, 0, ncyc);
    chk("tp_word_cycles", ncyc, 1);
    chk("tp_word_rdata", rdata_o, 32'h1122_3344);

    // Byte loads, signed and unsigned.
    run_txn(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0, 32'h80AA_BBCC, 0, ncyc);
    chk("tp_sbyte_rdata", rdata_o, 32'hFFFF_FF80);
    run_txn(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'd0, 32'h80AA_BBCC, 0, ncyc);
    chk("tp_ubyte_rdata", rdata_o, 32'h0000_0080);

    // Half store with three stall cycles: write held for four cycles.
    run_txn(1'b1, 2'd1, 1'b0, 32'h2000_0002, 32'h0000_ABCD, 32'd0, 3, ncyc);
    chk("tp_hstore_cycles", ncyc, 4);
    chk("tp_hstore_wd_hi", {16'd0, writedata[31:16]}, 32'h0000_CDAB);

    // Misaligned word load: no bus access, rdata unchanged.
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 32'h1234_5678, 0, ncyc);
    chk("tp_mis_cycles", ncyc, 0);
    chk("tp_mis_rdata", rdata_o, 32'h0000_0080);

    // Timeout with waitrequest stuck high, then a normal request.
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'h0, 50, ncyc);
    chk("tp_to_cycles", ncyc, TO);
    chk("tp_to_rdata", rdata_o, 32'd0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 32'h9ABC_0000, 1, ncyc);
    chk("tp_after_to_rdata", rdata_o, 32'hFFFF_BC9A);

    // Reset pulsed mid-transfer with waitrequest high.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h3000_0000; waitrequest = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    chk("rstmid_read_before", {31'd0, read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 32'd0;
    chk("rstmid_read", {31'd0, read}, 32'd0);
    chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
    chk("rstmid_done", {31'd0, done_o}, 32'd0);
    chk("rstmid_address", address, 32'd0);
    chk("rstmid_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rstmid_writedata", writedata, 32'd0);
    chk("rstmid_rdata", rdata_o, 32'd0);
    @(negedge clk);
    chk("rstmid_no_done", {31'd0, done_o}, 32'd0);

    // Randomized transactions against the model.
    for (int t = 0; t < 120; t++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'd0;
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, $urandom,
              ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 3), ncyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_lsu.md
Name: mips_bus_lsu

Overview:
- Load/store unit sitting between the multicycle MIPS core and the Avalon memory-mapped master port.
- Turns one core memory request (byte/half/word, signed/unsigned) into a single Avalon transfer, stretching it across waitrequest stalls.
- Generates byteenable and lane-aligned writedata, converts endianness, and sign/zero-extends load data.
- Reports completion, stall, misalignment and bus-timeout status back to the core FSM.

Parameters:
- BIG_ENDIAN_CORE, 1, 1: core is big-endian over the byte-lane-addressed bus, so bytes are swapped within half/word; 0: plain lane order.
- TIMEOUT_CYCLES, 0, waitrequest-stall cycles before the transfer is abandoned; 0 disables the timeout.
- CNT_WIDTH, 16, width of the stall counter; must satisfy TIMEOUT_CYCLES < 2^CNT_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_i  in  1  start request; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- sign_ext_i  in  1  loads: 1 sign-extend, 0 zero-extend
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified
- busy_o  out  1  state != IDLE; core must stall
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result; held until the next accepted request
- misalign_o  out  1  valid with done_o: address misaligned, no bus access made
- timeout_o  out  1  valid with done_o: transfer abandoned after timeout
- address  out  32  word-aligned bus address
- write  out  1  Avalon write
- read  out  1  Avalon read
- waitrequest  in  1  Avalon waitrequest
- writedata  out  32  lane-formatted store data
- byteenable  out  4  active byte lanes
- readdata  in  32  Avalon read data, valid in the cycle waitrequest is low

Behaviour:
- Reset state:
  - State IDLE; read = write = 0.
  - address = 0, writedata = 0, byteenable = 0.
  - rdata_o = 0; done_o, misalign_o, timeout_o, busy_o all 0; stall counter = 0.
- Reset mid-transfer: state returns to IDLE at the reset edge, read/write drop in the same cycle, no done_o is produced.
- Lanes: byte address A+k maps to lane k, bits 8k+7:8k. off = addr[1:0].
- Misaligned request: half with off[0] = 1, or word with off != 0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - On req_i, latch we/size/sign/addr/wdata.
  - Misaligned: go to DONE with misalign_o = 1 and rdata_o unchanged.
  - Otherwise: go to BUS and clear the counter.
  - req_i in any other state is ignored.
- BUS:
  - read = !we, write = we.
  - address = {addr[31:2], 2'b00}; byteenable and writedata registered, held stable for the whole state.
  - waitrequest = 1: increment the counter. If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1, go to DONE with timeout_o = 1, rdata_o = 0, read/write dropped.
  - waitrequest = 0: transfer accepted this cycle. On a load, register the formatted readdata into rdata_o. Go to DONE.
- DONE: done_o = 1 for exactly one cycle, read = write = 0, flags valid, then IDLE.
- Flags: misalign_o and timeout_o are cleared on the next accepted request.
- Latency: req in cycle 0, bus access in cycle 1; with zero wait states done_o rises in cycle 2; each stall cycle adds 1.
- Misaligned-request latency: done_o rises in cycle 1.
- byteenable:
  - byte: 1 << off.
  - half: off = 0 gives 0011, off = 2 gives 1100.
  - word: 1111.
- writedata, BIG_ENDIAN_CORE = 1:
  - byte: {4{w[7:0]}}.
  - half: {2{w[7:0], w[15:8]}}.
  - word: {w[7:0], w[15:8], w[23:16], w[31:24]}.
- writedata, BIG_ENDIAN_CORE = 0: byte and half replicated unswapped; word passed through.
- Load data, BIG_ENDIAN_CORE = 1:
  - byte: lane[off].
  - half: {lane[off], lane[off+1]}.
  - word: {lane0, lane1, lane2, lane3}.
- Load data, BIG_ENDIAN_CORE = 0: unswapped.
- Extension: sign_ext_i = 1 extends the MSB of the byte/half; 0 pads with zeros. Words are unaffected.

Test Plan:
- Word load, addr 0x10000004, readdata 0x44332211, no wait states -> read only in cycle 1, address 0x10000004, byteenable 1111, done_o in cycle 2, rdata_o 0x11223344.
- Signed byte load at 0x10000003, readdata 0x80AABBCC -> byteenable 1000, rdata_o 0xFFFFFF80; repeat with sign_ext_i = 0 -> rdata_o 0x00000080.
- Half store at 0x20000002, wdata 0x0000ABCD, waitrequest high 3 cycles -> write held 4 cycles; address, writedata[31:16] = 0xCDAB and byteenable 1100 all stable; done_o on the cycle after release.
- Word load at 0x00000006 -> read never asserted, done_o with misalign_o = 1 in cycle 1, rdata_o unchanged.
- TIMEOUT_CYCLES = 4, waitrequest stuck high -> read asserted 4 cycles then dropped, done_o with timeout_o = 1 and rdata_o = 0; a new request then proceeds normally.
- reset pulsed during BUS with waitrequest high -> next cycle: read = 0, busy_o = 0, all outputs at reset values, no done_o pulse.
